// File: rtl/periph_bus_pkg.sv
// Shared types and constants for the two-master peripheral register bus arbiter.
package periph_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef logic [0:0] mst_idx_t;

  localparam mst_idx_t M0 = 1'b0;
  localparam mst_idx_t M1 = 1'b1;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_req_t;

  localparam logic [31:0] DEF_BASEADDRESS = 32'h8000_0000;
  localparam logic [31:0] DEF_NOREGISTERS = 32'h0000_0004;

  // 33-bit compare so a window touching the top of the address space never wraps.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] nregs);
    logic [32:0] a33;
    logic [32:0] lo33;
    logic [32:0] hi33;
    a33  = {1'b0, addr};
    lo33 = {1'b0, base};
    hi33 = {1'b0, base} + {1'b0, nregs};
    return (a33 >= lo33) && (a33 < hi33);
  endfunction

endpackage

// File: rtl/periph_rr_pick.sv
// Combinational two-way round-robin pick: on a tie the master other than last_grant wins.
module periph_rr_pick
  import periph_bus_pkg::*;
(
  input  logic [1:0] req,
  input  mst_idx_t   last_grant,
  output logic       valid,
  output mst_idx_t   sel
);

  always_comb begin
    valid = |req;
    sel   = M0;
    if (req == 2'b11) begin
      sel = mst_idx_t'(~last_grant);
    end else if (req[1]) begin
      sel = M1;
    end
  end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Two-master round-robin arbiter/sequencer for the strobe-based peripheral register bus.
// Optional M0_ERR/M1_ERR outputs are enabled with `define PERIPH_BUS_ARBITER_ERR_EN.
module periph_bus_arbiter
  import periph_bus_pkg::*;
#(
  parameter logic [31:0] BASEADDRESS = DEF_BASEADDRESS,
  parameter logic [31:0] NOREGISTERS = DEF_NOREGISTERS,
  parameter int unsigned RDLATENCY   = 1
) (
  input  logic        ACLK,
  input  logic        RESET_N,
  input  logic        M0_REQ,
  input  logic        M0_WE,
  input  logic [31:0] M0_ADDR,
  input  logic [31:0] M0_WDATA,
  output logic        M0_ACK,
  output logic [31:0] M0_RDATA,
  input  logic        M1_REQ,
  input  logic        M1_WE,
  input  logic [31:0] M1_ADDR,
  input  logic [31:0] M1_WDATA,
  output logic        M1_ACK,
  output logic [31:0] M1_RDATA,
  output logic [31:0] S_ADDR,
  output logic [31:0] S_WDATA,
  input  logic [31:0] S_RDATA,
  output logic        S_WRSTB,
  output logic        S_RDSTB,
`ifdef PERIPH_BUS_ARBITER_ERR_EN
  output logic        M0_ERR,
  output logic        M1_ERR,
`endif
  output logic [1:0]  GRANT
);

  localparam logic [1:0] CNT_LOAD = 2'(RDLATENCY - 1);

  arb_state_e state_q, state_d;
  mst_idx_t   owner_q, owner_d;
  mst_idx_t   last_q, last_d;
  bus_req_t   req_q, req_d;
  logic [1:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;

  bus_req_t m0_in, m1_in;
  logic     pick_valid;
  mst_idx_t pick_sel;

  assign m0_in = '{we: M0_WE, addr: M0_ADDR, wdata: M0_WDATA};
  assign m1_in = '{we: M1_WE, addr: M1_ADDR, wdata: M1_WDATA};

  periph_rr_pick u_pick (
    .req        ({M1_REQ, M0_REQ}),
    .last_grant (last_q),
    .valid      (pick_valid),
    .sel        (pick_sel)
  );

  always_ff @(posedge ACLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      owner_q <= M0;
      last_q  <= M1;
      req_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d = pick_sel;
          last_d  = pick_sel;
          req_d   = (pick_sel == M1) ? m1_in : m0_in;
          // Cleared here so writes and out-of-window accesses return 0.
          rdata_d = '0;
          state_d = in_window(req_d.addr, BASEADDRESS, NOREGISTERS) ? ISSUE : RESP;
        end
      end
      ISSUE: begin
        if (req_q.we) begin
          state_d = RESP;
        end else begin
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 2'd1;
        end else begin
          rdata_d = S_RDATA;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    GRANT    = '0;
    S_ADDR   = '0;
    S_WDATA  = '0;
    S_WRSTB  = 1'b0;
    S_RDSTB  = 1'b0;
    M0_ACK   = 1'b0;
    M0_RDATA = '0;
    M1_ACK   = 1'b0;
    M1_RDATA = '0;
`ifdef PERIPH_BUS_ARBITER_ERR_EN
    M0_ERR   = 1'b0;
    M1_ERR   = 1'b0;
`endif
    if (state_q != IDLE) begin
      GRANT   = (owner_q == M1) ? 2'b10 : 2'b01;
      S_ADDR  = req_q.addr;
      S_WDATA = req_q.wdata;
    end
    if (state_q == ISSUE) begin
      S_WRSTB = req_q.we;
      S_RDSTB = ~req_q.we;
    end
    if (state_q == RESP) begin
      if (owner_q == M1) begin
        M1_ACK   = 1'b1;
        M1_RDATA = rdata_q;
      end else begin
        M0_ACK   = 1'b1;
        M0_RDATA = rdata_q;
      end
`ifdef PERIPH_BUS_ARBITER_ERR_EN
      // The latched address alone tells whether this response skipped the slave.
      if (!in_window(req_q.addr, BASEADDRESS, NOREGISTERS)) begin
        M0_ERR = (owner_q == M0);
        M1_ERR = (owner_q == M1);
      end
`endif
    end
  end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Directed, table-driven bench for periph_bus_arbiter (RDLATENCY=1 and RDLATENCY=3 instances).
module tb_periph_bus_arbiter;

  logic ACLK = 1'b0;
  logic RESET_N = 1'b0;
  always #5 ACLK = ~ACLK;

`ifdef PERIPH_BUS_ARBITER_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;

  logic        d1_a0, d1_a1, d1_wr, d1_rd, d3_a0, d3_a1, d3_wr, d3_rd;
  logic [31:0] d1_r0, d1_r1, d1_saddr, d1_swdata, d3_r0, d3_r1, d3_saddr, d3_swdata;
  logic [1:0]  d1_grant, d3_grant, d1_err, d3_err;

  typedef struct packed {
    logic [1:0]  grant;
    logic        wr;
    logic        rd;
    logic [31:0] saddr;
    logic [31:0] swdata;
    logic        a0;
    logic [31:0] r0;
    logic        a1;
    logic [31:0] r1;
    logic [1:0]  err;
  } obs_t;

  typedef struct {
    logic        r0, w0;
    logic [31:0] a0, wd0;
    logic        r1, w1;
    logic [31:0] a1, sr;
    obs_t        exp;
  } vec_t;

  obs_t o1, o3;
  assign o1 = {d1_grant, d1_wr, d1_rd, d1_saddr, d1_swdata, d1_a0, d1_r0, d1_a1, d1_r1, d1_err};
  assign o3 = {d3_grant, d3_wr, d3_rd, d3_saddr, d3_swdata, d3_a0, d3_r0, d3_a1, d3_r1, d3_err};

`ifdef PERIPH_BUS_ARBITER_ERR_EN
  logic d1_e0, d1_e1, d3_e0, d3_e1;
  assign d1_err = {d1_e1, d1_e0};
  assign d3_err = {d3_e1, d3_e0};
`else
  assign d1_err = '0;
  assign d3_err = '0;
`endif

  periph_bus_arbiter #(.RDLATENCY(1)) dut1 (
    .ACLK(ACLK), .RESET_N(RESET_N),
    .M0_REQ(m0_req), .M0_WE(m0_we), .M0_ADDR(m0_addr), .M0_WDATA(m0_wdata),
    .M0_ACK(d1_a0), .M0_RDATA(d1_r0),
    .M1_REQ(m1_req), .M1_WE(m1_we), .M1_ADDR(m1_addr), .M1_WDATA(m1_wdata),
    .M1_ACK(d1_a1), .M1_RDATA(d1_r1),
    .S_ADDR(d1_saddr), .S_WDATA(d1_swdata), .S_RDATA(s_rdata),
    .S_WRSTB(d1_wr), .S_RDSTB(d1_rd),
`ifdef PERIPH_BUS_ARBITER_ERR_EN
    .M0_ERR(d1_e0), .M1_ERR(d1_e1),
`endif
    .GRANT(d1_grant)
  );

  periph_bus_arbiter #(.RDLATENCY(3)) dut3 (
    .ACLK(ACLK), .RESET_N(RESET_N),
    .M0_REQ(m0_req), .M0_WE(m0_we), .M0_ADDR(m0_addr), .M0_WDATA(m0_wdata),
    .M0_ACK(d3_a0), .M0_RDATA(d3_r0),
    .M1_REQ(m1_req), .M1_WE(m1_we), .M1_ADDR(m1_addr), .M1_WDATA(m1_wdata),
    .M1_ACK(d3_a1), .M1_RDATA(d3_r1),
    .S_ADDR(d3_saddr), .S_WDATA(d3_swdata), .S_RDATA(s_rdata),
    .S_WRSTB(d3_wr), .S_RDSTB(d3_rd),
`ifdef PERIPH_BUS_ARBITER_ERR_EN
    .M0_ERR(d3_e0), .M1_ERR(d3_e1),
`endif
    .GRANT(d3_grant)
  );

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic obs_t mko(input logic [1:0] g, input logic wr, input logic rd,
                               input logic [31:0] sa, input logic [31:0] sw,
                               input logic a0, input logic [31:0] r0,
                               input logic a1, input logic [31:0] r1, input logic [1:0] e);
    obs_t o;
    o = {g, wr, rd, sa, sw, a0, r0, a1, r1, (ERR_ON ? e : 2'b00)};
    return o;
  endfunction

  function automatic vec_t mk(input logic r0, input logic w0, input logic [31:0] a0,
                              input logic [31:0] wd0, input logic r1, input logic w1,
                              input logic [31:0] a1, input logic [31:0] sr, input obs_t e);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.wd0 = wd0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.sr = sr; v.exp = e;
    return v;
  endfunction

  task automatic clear_inputs();
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    s_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    RESET_N = 1'b0;
    clear_inputs();
    @(negedge ACLK);
    RESET_N = 1'b1;
  endtask

  // Observe dut3 from the cycle a request is presented (cycle 0); slave data in cycle k is 0x11111111*(k+1).
  task automatic txn3(output int sc, output int ns, output int ac, output logic [31:0] rd);
    sc = -1; ns = 0; ac = -1; rd = '0;
    s_rdata = 32'h1111_1111;
    for (int k = 0; k < 16; k++) begin
      #1;
      if (d3_wr || d3_rd) begin
        ns++;
        if (sc < 0) sc = k;
      end
      if (d3_a0 || d3_a1) begin
        ac = k;
        rd = d3_a0 ? d3_r0 : d3_r1;
        break;
      end
      @(negedge ACLK);
      s_rdata = 32'h1111_1111 * (k + 2);
    end
    @(negedge ACLK);
    clear_inputs();
  endtask

  vec_t tbl[12];
  obs_t z;

  initial begin
    int sc, ns, ac, n, viol, strobes, no_ack;
    logic [31:0] rd;
    logic order[4];
    logic pa0, pa1;

    clear_inputs();
    z = '0;
    tbl[0]  = mk(1, 1, 32'h8000_0000, 32'h0000_01FF, 0, 0, 32'h0, 32'h0, z);
    tbl[1]  = mk(1, 1, 32'h8000_0000, 32'h0000_01FF, 0, 0, 32'h0, 32'h0,
                 mko(2'b01, 1, 0, 32'h8000_0000, 32'h0000_01FF, 0, 0, 0, 0, 2'b00));
    tbl[2]  = mk(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0,
                 mko(2'b01, 0, 0, 32'h8000_0000, 32'h0000_01FF, 1, 0, 0, 0, 2'b00));
    tbl[3]  = mk(0, 0, 32'h0, 32'h0, 1, 0, 32'h8000_0001, 32'h0, z);
    tbl[4]  = mk(0, 0, 32'h0, 32'h0, 1, 0, 32'h8000_0001, 32'h0,
                 mko(2'b10, 0, 1, 32'h8000_0001, 32'h0, 0, 0, 0, 0, 2'b00));
    tbl[5]  = mk(0, 0, 32'h0, 32'h0, 1, 0, 32'h8000_0001, 32'h0002_ABCD,
                 mko(2'b10, 0, 0, 32'h8000_0001, 32'h0, 0, 0, 0, 0, 2'b00));
    tbl[6]  = mk(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'hDEAD_BEEF,
                 mko(2'b10, 0, 0, 32'h8000_0001, 32'h0, 0, 0, 1, 32'h0002_ABCD, 2'b00));
    tbl[7]  = mk(1, 0, 32'h8000_0004, 32'h0, 0, 0, 32'h0, 32'h0, z);
    tbl[8]  = mk(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0,
                 mko(2'b01, 0, 0, 32'h8000_0004, 32'h0, 1, 0, 0, 0, 2'b01));
    tbl[9]  = mk(0, 0, 32'h0, 32'h0, 1, 0, 32'h7FFF_FFFF, 32'h0, z);
    tbl[10] = mk(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0,
                 mko(2'b10, 0, 0, 32'h7FFF_FFFF, 32'h0, 0, 0, 1, 0, 2'b10));
    tbl[11] = mk(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, z);

    // Reset state of both instances.
    @(negedge ACLK);
    #1;
    chk("reset_dut1", o1, z);
    chk("reset_dut3", o3, z);
    @(negedge ACLK);
    RESET_N = 1'b1;

    // Cycle-by-cycle vectors against the RDLATENCY=1 instance.
    for (int i = 0; i < 12; i++) begin
      @(negedge ACLK);
      m0_req = tbl[i].r0; m0_we = tbl[i].w0; m0_addr = tbl[i].a0; m0_wdata = tbl[i].wd0;
      m1_req = tbl[i].r1; m1_we = tbl[i].w1; m1_addr = tbl[i].a1; m1_wdata = '0;
      s_rdata = tbl[i].sr;
      #1;
      chk($sformatf("vec%0d", i), o1, tbl[i].exp);
    end

    // Both masters hold write requests: grants must alternate starting with M0.
    do_reset();
    m0_req = 1; m0_we = 1; m0_addr = 32'h8000_0000; m0_wdata = 32'h0000_AAAA;
    m1_req = 1; m1_we = 1; m1_addr = 32'h8000_0002; m1_wdata = 32'h0000_BBBB;
    n = 0; viol = 0; strobes = 0; pa0 = 0; pa1 = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      #1;
      if (d1_a0 && d1_a1) viol++;
      if (d1_wr && d1_rd) viol++;
      if ((d1_a0 && pa0) || (d1_a1 && pa1)) viol++;
      if (d1_a0 && d1_grant != 2'b01) viol++;
      if (d1_a1 && d1_grant != 2'b10) viol++;
      strobes += int'(d1_wr) + int'(d1_rd);
      if (d1_a0) begin order[n] = 1'b0; n++; end
      else if (d1_a1) begin order[n] = 1'b1; n++; end
      pa0 = d1_a0; pa1 = d1_a1;
      @(negedge ACLK);
    end
    chk("rr_ack_count", 136'(n), 136'(4));
    for (int i = 0; i < 4; i++) chk($sformatf("rr_order%0d", i), 136'(order[i]), 136'(i % 2));
    chk("rr_violations", 136'(viol), 136'(0));
    chk("rr_strobes", 136'(strobes), 136'(4));
    clear_inputs();

    // Reset asserted while an M1 read waits out RDLATENCY=3.
    do_reset();
    m1_req = 1; m1_we = 0; m1_addr = 32'h8000_0001;
    @(negedge ACLK);
    @(negedge ACLK);
    #1;
    chk("wait_grant", 136'({d3_grant, d3_wr, d3_rd}), 136'({2'b10, 1'b0, 1'b0}));
    #1;
    RESET_N = 1'b0;
    #1;
    chk("reset_mid_wait", o3, z);
    m1_req = 0;
    @(negedge ACLK);
    RESET_N = 1'b1;
    no_ack = 1;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (d3_a0 || d3_a1 || d3_wr || d3_rd) no_ack = 0;
      @(negedge ACLK);
    end
    chk("no_ack_after_abort", 136'(no_ack), 136'(1));
    m0_req = 1; m0_we = 1; m0_addr = 32'h8000_0000; m0_wdata = 32'h1234_5678;
    txn3(sc, ns, ac, rd);
    chk("post_reset_wr_strobe_cyc", 136'(sc), 136'(1));
    chk("post_reset_wr_strobes", 136'(ns), 136'(1));
    chk("post_reset_wr_ack_cyc", 136'(ac), 136'(2));

    // RDLATENCY=3 read at the top of the window: data from cycle 4 only.
    do_reset();
    m0_req = 1; m0_we = 0; m0_addr = 32'h8000_0003;
    txn3(sc, ns, ac, rd);
    chk("lat3_strobe_cyc", 136'(sc), 136'(1));
    chk("lat3_strobes", 136'(ns), 136'(1));
    chk("lat3_ack_cyc", 136'(ac), 136'(5));
    chk("lat3_rdata", 136'(rd), 136'(32'h5555_5555));

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/periph_bus_arbiter.md
Name: periph_bus_arbiter

Overview:
- Two-master arbiter and sequencer for the strobe-based peripheral register bus.
- The slave is the GPIO/peripheral register bank, with single-cycle WRSTB/RDSTB and a registered DATA_O.
- Masters are the CPU data port (M0) and a debug/loader port (M1).
- Grants round-robin, issues exactly one strobe per transaction, waits out the slave read latency, and returns data with a one-cycle ACK.

Parameters:
- BASEADDRESS, 32'h8000_0000, first decoded slave address.
- NOREGISTERS, 32'h0000_0004, number of decoded addresses; the window is [BASEADDRESS, BASEADDRESS+NOREGISTERS).
- RDLATENCY, 1, cycles from S_RDSTB to valid S_RDATA (legal range 1..3).

Ports:
- ACLK  in  1  clock
- RESET_N  in  1  asynchronous active-low reset
- M0_REQ, M1_REQ  in  1  request; held with ADDR/WE/WDATA until ACK
- M0_WE, M1_WE  in  1  1 = write, 0 = read
- M0_ADDR, M1_ADDR  in  32  byte address
- M0_WDATA, M1_WDATA  in  32  write data
- M0_ACK, M1_ACK  out  1  one-cycle completion pulse
- M0_RDATA, M1_RDATA  out  32  read data, valid only while ACK=1
- S_ADDR  out  32  slave address
- S_WDATA  out  32  to slave DATA_I
- S_RDATA  in  32  from slave DATA_O
- S_WRSTB, S_RDSTB  out  1  slave strobes
- GRANT  out  2  one-hot current owner; 00 when idle

Behaviour:
- Reset (RESET_N=0, asynchronous):
  - State IDLE; all outputs 0.
  - last_grant=M1, so M0 wins the first tie.
  - Reset mid-transaction aborts with no ACK and no further strobe.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - No REQ: stay.
  - One REQ: select that master.
  - Both REQ: select the master not equal to last_grant.
  - On selection, latch ADDR/WE/WDATA/owner and update last_grant.
  - In-window address: go to ISSUE. Out-of-window: go to RESP with captured data 0; no strobe ever issued.
- ISSUE (exactly 1 cycle):
  - Assert S_WRSTB (WE=1) or S_RDSTB (WE=0).
  - Write: go to RESP. Read: load counter with RDLATENCY-1 and go to WAIT.
- WAIT:
  - Counter nonzero: decrement.
  - Counter zero: capture S_RDATA into the read register and go to RESP.
- RESP (1 cycle):
  - Owner's ACK=1; owner's RDATA = captured data (0 for writes). Then go to IDLE.
  - The non-owner's ACK and RDATA stay 0.
- S_ADDR/S_WDATA:
  - Outside IDLE: driven from latched values.
  - In IDLE: 0.
- Strobes are 0 outside ISSUE; never more than one strobe per transaction.
- GRANT is one-hot owner in ISSUE/WAIT/RESP and 00 in IDLE.
- Latency, measured from the cycle REQ is sampled in IDLE (cycle 0):
  - Write: strobe at cycle 1, ACK at cycle 2.
  - Read: strobe at cycle 1, ACK at cycle 2+RDLATENCY.
  - Out-of-range: ACK at cycle 1.
- REQ dropped mid-transaction: the transaction still completes and ACKs; requests are not cancelled.
- REQ still high in the IDLE cycle after ACK is a new request. Round-robin still applies, so a continuously requesting master alternates with the other.
- Window check uses full 32-bit unsigned compare; BASEADDRESS+NOREGISTERS is computed in 33 bits, so there is no wrap at the top of the address space.

Optional Feature:
- Macro PERIPH_BUS_ARBITER_ERR_EN.
- Defined:
  - Adds ports M0_ERR and M1_ERR (out, 1).
  - ERR pulses together with ACK for an out-of-window access; reset value 0.
- Undefined:
  - No ERR ports.
  - Out-of-window accesses ACK silently with RDATA=0.
- All other timing is identical either way.

Decomposition:
- Package periph_bus_pkg:
  - State enum arb_state_e {IDLE, ISSUE, WAIT, RESP}.
  - Master index type (logic [0:0]).
  - Request struct {we, addr, wdata}.
  - Default BASEADDRESS/NOREGISTERS constants.
- Sub-module periph_rr_pick (combinational two-way round-robin):
  - Inputs: req[1:0], last_grant.
  - Outputs: valid, sel.
  - Reusable for future masters.

Test Plan:
- Reset, then M0 write 32'h0000_01FF to 32'h8000_0000:
  - S_WRSTB=1 exactly at cycle 1 with S_ADDR 32'h8000_0000 and S_WDATA 32'h0000_01FF.
  - M0_ACK at cycle 2; GRANT=01 through RESP.
- M1 read 32'h8000_0001, slave returning 32'h0002_ABCD one cycle after strobe (RDLATENCY=1):
  - M1_ACK at cycle 3 with M1_RDATA 32'h0002_ABCD.
  - M0_ACK stays 0.
- M0 and M1 REQ together, held through four transactions:
  - Grant order M0, M1, M0, M1.
  - Each ACK is a single cycle; strobes never overlap.
- M0 read 32'h8000_0004 (out of window):
  - No strobe; M0_ACK at cycle 1 with RDATA 0.
  - With PERIPH_BUS_ARBITER_ERR_EN, M0_ERR=1 in the same cycle.
- RESET_N asserted during WAIT of an M1 read with RDLATENCY=3:
  - Outputs 0 immediately; no M1_ACK.
  - After release, an M0 write completes in 2 cycles.
- RDLATENCY=3 read:
  - ACK at cycle 5.
  - Data captured is the slave value present in cycle 4, not earlier values.
